// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, fetch
// granularity and the default reset fetch address.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    VALID
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES    = 4;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch: issues one word read per instruction
// to a 1-cycle-latency memory and holds the result until the consumer accepts it.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next;
  logic         capture;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      instr    <= '0;
      instr_pc <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (capture) begin
        instr    <= mem_rdata;
        instr_pc <= pc;
      end
    end
  end

  // A redirect overrides every state, including a VALID-cycle handshake,
  // and suppresses capture of any response still in flight.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    capture    = 1'b0;
    if (redirect_valid) begin
      pc_next    = {redirect_pc[31:2], 2'b00};
      state_next = halt ? IDLE : REQ;
    end else begin
      case (state)
        IDLE: begin
          if (!halt) state_next = REQ;
        end
        REQ: begin
          state_next = RESP;
        end
        RESP: begin
          capture    = 1'b1;
          state_next = VALID;
        end
        VALID: begin
          if (instr_ready) begin
            pc_next    = pc + 32'(INSTR_BYTES);
            state_next = halt ? IDLE : REQ;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign mem_addr    = pc;
  assign mem_rstrb   = (state == REQ);
  assign instr_valid = (state == VALID);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: cycle-by-cycle vector tables plus a
// scoreboard of instructions expected at each consumer handshake.
module tb_instr_fetch;

  localparam logic [31:0] I0 = 32'h0000_0033;
  localparam logic [31:0] I1 = 32'h0200_0113;
  localparam logic [31:0] I2 = 32'h0010_8093;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_rdata = '0;
  logic        halt = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic [31:0] mem [256];

  typedef struct {
    logic        halt;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        e_rstrb;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .mem_addr       (mem_addr),
    .mem_rstrb      (mem_rstrb),
    .mem_rdata      (mem_rdata),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rstrb) mem_rdata <= mem[mem_addr[9:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Handshake monitor: every accepted instruction must match the next scoreboard entry.
  always @(negedge clk) begin
    if (resetn && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_handshake", instr_pc, 32'hFFFF_FFFF);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("sb_pc", instr_pc, e.pc);
        chk("sb_instr", instr, e.word);
      end
    end
  end

  function automatic vec_t mk(input logic h, input logic r, input logic rd, input logic [31:0] rp,
                              input logic es, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.halt = h; v.ready = r; v.redir = rd; v.rpc = rp;
    v.e_rstrb = es; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_ipc = ep;
    return v;
  endfunction

  task automatic sb_push(input logic [31:0] pc, input logic [31:0] word);
    sb_t e;
    e.pc = pc; e.word = word;
    sb.push_back(e);
  endtask

  // Starts at posedge+1; drives each vector, compares at negedge, ends at the next posedge+1.
  task automatic run_vectors(input string tag);
    foreach (tbl[i]) begin
      halt           = tbl[i].halt;
      instr_ready    = tbl[i].ready;
      redirect_valid = tbl[i].redir;
      redirect_pc    = tbl[i].rpc;
      @(negedge clk);
      chk({tag, "_rstrb"}, 32'(mem_rstrb), 32'(tbl[i].e_rstrb));
      chk({tag, "_addr"}, mem_addr, tbl[i].e_addr);
      chk({tag, "_valid"}, 32'(instr_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        chk({tag, "_instr"}, instr, tbl[i].e_instr);
        chk({tag, "_ipc"}, instr_pc, tbl[i].e_ipc);
      end
      @(posedge clk);
      #1;
    end
    halt = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    tbl.delete();
  endtask

  // Asserts reset immediately, checks the asynchronous effect, releases at posedge+1.
  task automatic apply_reset();
    resetn = 1'b0;
    halt = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #1;
    chk("rst_rstrb", 32'(mem_rstrb), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ipc", instr_pc, 32'h0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic chk_sb_drained(input string tag);
    chk({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[0] = I0; mem[1] = I1; mem[2] = I2;

    #3;
    apply_reset();

    // Streaming fetch, then a 5-cycle consumer stall on the second instruction.
    sb_push(32'h0, I0); sb_push(32'h4, I1); sb_push(32'h8, I2);
    tbl.push_back(mk(0,1,0,0, 0,32'h0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 0,32'h0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 0,32'h0,1,I0,32'h0));
    tbl.push_back(mk(0,0,0,0, 1,32'h4,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,32'h4,0,0,0));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(0,0,0,0, 0,32'h4,1,I1,32'h4));
    tbl.push_back(mk(0,1,0,0, 0,32'h4,1,I1,32'h4));
    tbl.push_back(mk(0,1,0,0, 1,32'h8,0,0,0));
    tbl.push_back(mk(0,1,0,0, 0,32'h8,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,32'h8,1,I2,32'h8));
    tbl.push_back(mk(0,0,0,0, 0,32'h8,1,I2,32'h8));
    tbl.push_back(mk(0,1,0,0, 0,32'h8,1,I2,32'h8));
    tbl.push_back(mk(0,0,0,0, 1,32'hC,0,0,0));
    run_vectors("stream");
    chk_sb_drained("stream");

    // Redirect to 0x9 during RESP of the 0x4 fetch: that word is dropped.
    apply_reset();
    sb_push(32'h0, I0); sb_push(32'h8, I2);
    tbl.push_back(mk(0,1,0,0, 0,32'h0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 0,32'h0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 0,32'h0,1,I0,32'h0));
    tbl.push_back(mk(0,1,0,0, 1,32'h4,0,0,0));
    tbl.push_back(mk(0,1,1,32'h9, 0,32'h4,0,0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h8,0,0,0));
    tbl.push_back(mk(0,1,0,0, 0,32'h8,0,0,0));
    tbl.push_back(mk(0,1,0,0, 0,32'h8,1,I2,32'h8));
    run_vectors("redir");
    chk_sb_drained("redir");

    // Halt raised in REQ: fetch completes, then IDLE with no strobes until halt drops.
    apply_reset();
    sb_push(32'h0, I0); sb_push(32'h4, I1);
    tbl.push_back(mk(0,0,0,0, 0,32'h0,0,0,0));
    tbl.push_back(mk(1,0,0,0, 1,32'h0,0,0,0));
    tbl.push_back(mk(1,0,0,0, 0,32'h0,0,0,0));
    tbl.push_back(mk(1,1,0,0, 0,32'h0,1,I0,32'h0));
    tbl.push_back(mk(1,0,0,0, 0,32'h4,0,0,0));
    tbl.push_back(mk(1,0,0,0, 0,32'h4,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,32'h4,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h4,0,0,0));
    tbl.push_back(mk(0,1,0,0, 0,32'h4,0,0,0));
    tbl.push_back(mk(0,1,0,0, 0,32'h4,1,I1,32'h4));
    run_vectors("halt");
    chk_sb_drained("halt");

    // Asynchronous reset mid-RESP, then redirect to the top word and wrap to 0.
    apply_reset();
    sb_push(32'h0, I0);
    tbl.push_back(mk(0,1,0,0, 0,32'h0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 0,32'h0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 0,32'h0,1,I0,32'h0));
    tbl.push_back(mk(0,1,0,0, 1,32'h4,0,0,0));
    run_vectors("pre_rst");
    #1;
    chk("mid_resp_valid", 32'(instr_valid), 32'd0);
    chk("mid_resp_addr", mem_addr, 32'h4);
    chk("mid_resp_instr", instr, I0);
    chk_sb_drained("pre_rst");
    apply_reset();
    sb_push(32'h0, I0); sb_push(32'hFFFF_FFFC, mem[255]);
    tbl.push_back(mk(0,1,0,0, 0,32'h0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 0,32'h0,0,0,0));
    tbl.push_back(mk(0,1,1,32'hFFFF_FFFC, 0,32'h0,1,I0,32'h0));
    tbl.push_back(mk(0,1,0,0, 1,32'hFFFF_FFFC,0,0,0));
    tbl.push_back(mk(0,1,0,0, 0,32'hFFFF_FFFC,0,0,0));
    tbl.push_back(mk(0,1,0,0, 0,32'hFFFF_FFFC,1,32'hC0DE_00FF,32'hFFFF_FFFC));
    tbl.push_back(mk(0,0,0,0, 1,32'h0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,32'h0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,32'h0,1,I0,32'h0));
    run_vectors("wrap");
    chk_sb_drained("wrap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, fetch address after reset (bits[1:0] SHALL be 0).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 mem_addr  output  32  byte address of read request; memory indexes word mem_addr[31:2].
REQ-005 mem_rstrb  output  1  read strobe; memory registers mem_rdata on the rising edge where it is high.
REQ-006 mem_rdata  input  32  read data, valid the cycle after the strobe cycle.
REQ-007 halt  input  1  when high, no new fetch SHALL start.
REQ-008 redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc.
REQ-009 redirect_pc  input  32  new fetch address; bits[1:0] ignored.
REQ-010 instr_valid  output  1  instr/instr_pc hold a fetched instruction.
REQ-011 instr  output  32  fetched instruction word.
REQ-012 instr_pc  output  32  byte address of instr.
REQ-013 instr_ready  input  1  consumer accepts instr when instr_valid and instr_ready are both high.

Function
REQ-014 FSM states: IDLE, REQ, RESP, VALID.
REQ-015 mem_addr SHALL equal the internal pc register at all times; mem_rstrb SHALL be high only in REQ.
REQ-016 IDLE -> REQ when halt=0; else stay in IDLE.
REQ-017 REQ -> RESP unconditionally (absent redirect).
REQ-018 RESP: instr <= mem_rdata and instr_pc <= pc at the clock edge; then -> VALID.
REQ-019 instr_valid SHALL be high exactly in VALID; instr and instr_pc SHALL stay stable while instr_valid=1 and instr_ready=0.
REQ-020 VALID with instr_ready=1: pc <= pc+4; -> REQ if halt=0, else -> IDLE.
REQ-021 VALID with instr_ready=0: stay in VALID regardless of halt.
REQ-022 Timing: strobe in cycle N; instr_valid high from cycle N+2; after a handshake in cycle M, the next strobe is in M+1 and the next instr_valid in M+3.
REQ-023 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 redirect_valid=1 in any state: pc <= {redirect_pc[31:2],2'b00}; the next state is REQ if halt=0, else IDLE; instr_valid SHALL be low the next cycle.
REQ-025 Redirect in REQ or RESP: the in-flight response SHALL never be captured into instr.
REQ-026 Redirect and handshake in the same VALID cycle: redirect wins; pc does not increment; the instruction counts as consumed.
REQ-027 halt rising during REQ or RESP SHALL NOT abort the in-flight fetch; it completes to VALID.

Reset
REQ-028 resetn=0 SHALL immediately force state=IDLE, pc=RESET_PC, instr=32'h0, instr_pc=RESET_PC, instr_valid=0, mem_rstrb=0, independent of clk.
REQ-029 Reset asserted mid-fetch SHALL discard the fetch; after release the first strobe SHALL occur in the first cycle after the IDLE exit.

Structure
REQ-030 A shared package fetch_pkg SHALL hold the state enum, INSTR_BYTES=4 and the RESET_PC default.
REQ-031 No sub-module; a single module holds the FSM, the pc register and the instr/instr_pc registers.

Verification
REQ-032 Bench pairs the block with a 256-word, 1-cycle-latency memory loaded with mem[0]=32'h00000033, mem[1]=32'h02000113, mem[2]=32'h00108093.
REQ-033 Reset release, halt=0, instr_ready=1 -> strobes at addresses 0x0, 0x4, 0x8; each instr/instr_pc pair matches memory (0x00000033/0x0, ...); one instruction every 3 cycles.
REQ-034 instr_ready=0 for 5 cycles while instr_valid=1 -> instr=32'h02000113 and instr_pc=0x4 stable; no strobe occurs; fetch resumes one cycle after ready returns.
REQ-035 redirect_valid with redirect_pc=0x9 asserted in the RESP cycle of the fetch at 0x4 -> 0x02000113 never appears; next strobe at mem_addr=0x8; instr_pc=0x8.
REQ-036 halt=1 raised in a REQ cycle -> that fetch reaches VALID; after the handshake the FSM enters IDLE with no further strobes until halt=0.
REQ-037 resetn pulsed low asynchronously mid-RESP -> outputs take reset values within the same cycle; after release the next fetch is at RESET_PC; a redirect to 0xFFFFFFFC followed by a handshake wraps the next fetch to 0x0.
